// File: rtl/reorder_buffer.sv
// In-order retirement queue: rename allocates entries, execution marks them done by
// tag, and done entries retire from the head in program order. Each retiring entry
// returns its old physical register to rename's free pool.
module reorder_buffer #(
    parameter int unsigned ROB_DEPTH    = 16,
    parameter int unsigned ROB_TAG_W    = 4,
    parameter int unsigned NUM_REG_LOG2 = 5
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    flush,
    input  logic                    alloc_valid,
    output logic                    alloc_ready,
    input  logic                    alloc_rd_valid,
    input  logic [NUM_REG_LOG2:0]   alloc_prd_old,
    input  logic [NUM_REG_LOG2:0]   alloc_prd_new,
    output logic [ROB_TAG_W-1:0]    alloc_tag,
    input  logic                    complete_valid,
    input  logic [ROB_TAG_W-1:0]    complete_tag,
    input  logic                    commit_stall,
    output logic                    commit_free,
    output logic [NUM_REG_LOG2:0]   prd_free,
    output logic                    retire_valid,
    output logic                    rob_empty
);

    localparam int unsigned PRD_W = NUM_REG_LOG2 + 1;
    localparam int unsigned CNT_W = ROB_TAG_W + 1;

    logic [ROB_DEPTH-1:0]             valid_q,    valid_d;
    logic [ROB_DEPTH-1:0]             done_q,     done_d;
    logic [ROB_DEPTH-1:0]             rd_valid_q, rd_valid_d;
    logic [ROB_DEPTH-1:0][PRD_W-1:0]  prd_old_q,  prd_old_d;
    logic [ROB_DEPTH-1:0][PRD_W-1:0]  prd_new_q,  prd_new_d;
    logic [ROB_TAG_W-1:0]             head_q,     head_d;
    logic [ROB_TAG_W-1:0]             tail_q,     tail_d;
    logic [CNT_W-1:0]                 count_q,    count_d;

    logic alloc_fire;
    logic complete_fire;

    // The new mapping is held per entry for rename-side recovery; retirement never reads it.
    logic unused_prd_new;
    assign unused_prd_new = ^prd_new_q;

    // Handshake and retirement outputs; full blocks allocation even if the head retires now.
    assign alloc_ready   = (count_q != CNT_W'(ROB_DEPTH));
    assign alloc_tag     = tail_q;
    assign rob_empty     = (count_q == CNT_W'(0));
    assign retire_valid  = valid_q[head_q] & done_q[head_q] & ~commit_stall & ~flush;
    assign commit_free   = retire_valid & rd_valid_q[head_q];
    assign prd_free      = commit_free ? prd_old_q[head_q] : PRD_W'(0);
    assign alloc_fire    = alloc_valid & alloc_ready & ~flush;
    assign complete_fire = complete_valid & ~flush & valid_q[complete_tag];

    // Next-state: complete, then retire, then allocate; flush overrides everything.
    always_comb begin
        valid_d    = valid_q;
        done_d     = done_q;
        rd_valid_d = rd_valid_q;
        prd_old_d  = prd_old_q;
        prd_new_d  = prd_new_q;
        head_d     = head_q;
        tail_d     = tail_q;
        count_d    = count_q;

        if (flush) begin
            valid_d = '0;
            done_d  = '0;
            head_d  = '0;
            tail_d  = '0;
            count_d = '0;
        end else begin
            if (complete_fire) begin
                done_d[complete_tag] = 1'b1;
            end
            if (retire_valid) begin
                valid_d[head_q] = 1'b0;
                done_d[head_q]  = 1'b0;
                head_d          = head_q + ROB_TAG_W'(1);
            end
            if (alloc_fire) begin
                valid_d[tail_q]    = 1'b1;
                done_d[tail_q]     = 1'b0;
                rd_valid_d[tail_q] = alloc_rd_valid;
                prd_old_d[tail_q]  = alloc_prd_old;
                prd_new_d[tail_q]  = alloc_prd_new;
                tail_d             = tail_q + ROB_TAG_W'(1);
            end
            case ({alloc_fire, retire_valid})
                2'b10:   count_d = count_q + CNT_W'(1);
                2'b01:   count_d = count_q - CNT_W'(1);
                default: count_d = count_q;
            endcase
        end
    end

    // State registers with asynchronous active-low reset.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            valid_q    <= '0;
            done_q     <= '0;
            rd_valid_q <= '0;
            prd_old_q  <= '0;
            prd_new_q  <= '0;
            head_q     <= '0;
            tail_q     <= '0;
            count_q    <= '0;
        end else begin
            valid_q    <= valid_d;
            done_q     <= done_d;
            rd_valid_q <= rd_valid_d;
            prd_old_q  <= prd_old_d;
            prd_new_q  <= prd_new_d;
            head_q     <= head_d;
            tail_q     <= tail_d;
            count_q    <= count_d;
        end
    end

endmodule
